// File: rtl/lsu_hs.sv
// lsu_hs - load/store unit with a valid/ready request/response handshake.
//
// Sits between the core's memory stage and the data memory plus memory-mapped
// I/O. One request is in flight at a time: IDLE accepts, RESP holds the
// response until the consumer takes it, so requests are spaced at least two
// cycles apart and the response is visible the cycle after the accept edge.
//
// Address map (byte address, selected by addr[13:12]):
//   00  DMEM, 2**DMEM_AW 32-bit words
//   01  input I/O words (read-only), N_IN words
//   10  output I/O registers, N_OUT words (readable and writable)
//   11  unmapped
//
// Ports:
//   clock_i         single clock, all state on the rising edge
//   reset_ni        synchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     request accepted when valid && ready
//   req_we_i        1 = store, 0 = load
//   req_addr_i      14-bit byte address
//   req_size_i      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i  zero-extend (1) / sign-extend (0) sub-word loads
//   req_wdata_i     right-aligned store data
//   rsp_valid_o     response present
//   rsp_ready_i     response consumed when valid && ready
//   rsp_rdata_o     load data (0 for stores and faults)
//   rsp_err_o       fault flag for this response
//   io_in_i         N_IN input words, word k at [32k+31:32k]
//   io_out_o        N_OUT output registers, same packing
//
// DMEM_AW must be in 1..10, since the word index field is addr[11:2].

module lsu_hs #(
  parameter int DMEM_AW = 10,
  parameter int N_IN    = 8,
  parameter int N_OUT   = 2
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [13:0]         req_addr_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [31:0]         req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  input  logic [32*N_IN-1:0]  io_in_i,
  output logic [32*N_OUT-1:0] io_out_o
);

  localparam int DMEM_WORDS = 2 ** DMEM_AW;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e       state_q;
  logic [31:0]  rdata_q;
  logic         err_q;
  logic [31:0]  dmem [DMEM_WORDS];
  logic [31:0]  outRegs_q [N_OUT];

  logic         accept;
  logic [1:0]   region;
  logic [1:0]   offset;
  logic [9:0]   wordIdx;
  logic [DMEM_AW-1:0] dmemIdx;
  logic         fault;
  logic [3:0]   sizeMask;
  logic [3:0]   byteEn;
  logic [31:0]  wdataRep;
  logic [31:0]  selWord;
  logic [31:0]  shiftedWord;
  logic [31:0]  loadData;
  logic [31:0]  rdata_d;
  logic         dmemWrite;
  logic         outWrite;

  // Handshake: ready only in IDLE and never while reset is held, so a request
  // presented during reset is not taken.
  assign req_ready_o = (state_q == IDLE) && reset_ni;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign accept      = req_valid_i && req_ready_o;

  assign region  = req_addr_i[13:12];
  assign offset  = req_addr_i[1:0];
  assign wordIdx = req_addr_i[11:2];
  assign dmemIdx = wordIdx[DMEM_AW-1:0];

  // Fault detection: alignment and size first, then per-region range and
  // access-type checks. A faulting request writes no state.
  always_comb begin
    fault = 1'b0;
    unique case (req_size_i)
      2'b01:   if (offset[0])      fault = 1'b1;
      2'b10:   if (offset != 2'b0) fault = 1'b1;
      2'b11:   fault = 1'b1;
      default: ;
    endcase
    unique case (region)
      2'b00: if ({22'b0, wordIdx} >= 32'(DMEM_WORDS)) fault = 1'b1;
      2'b01: if (req_we_i || ({22'b0, wordIdx} >= 32'(N_IN))) fault = 1'b1;
      2'b10: if ({22'b0, wordIdx} >= 32'(N_OUT)) fault = 1'b1;
      default: fault = 1'b1;
    endcase
  end

  // Store lane selection: the size mask is shifted onto the addressed lanes
  // and the data is replicated so every candidate lane carries the value.
  always_comb begin
    unique case (req_size_i)
      2'b00:   sizeMask = 4'b0001;
      2'b01:   sizeMask = 4'b0011;
      default: sizeMask = 4'b1111;
    endcase
    byteEn = sizeMask << offset;
    unique case (req_size_i)
      2'b00:   wdataRep = {4{req_wdata_i[7:0]}};
      2'b01:   wdataRep = {2{req_wdata_i[15:0]}};
      default: wdataRep = req_wdata_i;
    endcase
  end

  assign dmemWrite = accept && req_we_i && !fault && (region == 2'b00);
  assign outWrite  = accept && req_we_i && !fault && (region == 2'b10);

  // Load path: pick the addressed word, align the addressed byte to bit 0,
  // then extend according to size and signedness.
  always_comb begin
    selWord = '0;
    unique case (region)
      2'b00: selWord = dmem[dmemIdx];
      2'b01: begin
        for (int k = 0; k < N_IN; k++) begin
          if (wordIdx == k[9:0]) selWord = io_in_i[k*32 +: 32];
        end
      end
      2'b10: begin
        for (int k = 0; k < N_OUT; k++) begin
          if (wordIdx == k[9:0]) selWord = outRegs_q[k];
        end
      end
      default: ;
    endcase
    shiftedWord = selWord >> {offset, 3'b000};
    unique case (req_size_i)
      2'b00:   loadData = req_unsigned_i ? {24'b0, shiftedWord[7:0]}
                                         : {{24{shiftedWord[7]}}, shiftedWord[7:0]};
      2'b01:   loadData = req_unsigned_i ? {16'b0, shiftedWord[15:0]}
                                         : {{16{shiftedWord[15]}}, shiftedWord[15:0]};
      default: loadData = shiftedWord;
    endcase
    rdata_d = (fault || req_we_i) ? 32'b0 : loadData;
  end

  // DMEM write port. Contents are deliberately not reset.
  always_ff @(posedge clock_i) begin
    if (dmemWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) dmem[dmemIdx][b*8 +: 8] <= wdataRep[b*8 +: 8];
      end
    end
  end

  // Output I/O registers, cleared by reset and byte-lane writable.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      for (int k = 0; k < N_OUT; k++) outRegs_q[k] <= '0;
    end else if (outWrite) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (wordIdx == k[9:0]) begin
          for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) outRegs_q[k][b*8 +: 8] <= wdataRep[b*8 +: 8];
          end
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_OUT; g++) begin : gen_out
      assign io_out_o[g*32 +: 32] = outRegs_q[g];
    end
  endgenerate

  // Handshake FSM. Response data and error are captured only on accept, so
  // they stay stable for as long as the consumer stalls.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RESP;
            rdata_q <= rdata_d;
            err_q   <= fault;
          end
        end
        RESP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_hs.sv
// tb_lsu_hs - directed bench for lsu_hs.
//
// A table of complete transactions (request fields plus expected response and
// expected output register 0) is played in order, followed by hand-written
// sequences for response backpressure and reset in the RESP state.

module tb_lsu_hs;

  logic         clock = 1'b0;
  logic         resetN;
  logic         reqValid;
  logic         reqReady;
  logic         reqWe;
  logic [13:0]  reqAddr;
  logic [1:0]   reqSize;
  logic         reqUnsigned;
  logic [31:0]  reqWdata;
  logic         rspValid;
  logic         rspReady;
  logic [31:0]  rspRdata;
  logic         rspErr;
  logic [255:0] ioIn;
  logic [63:0]  ioOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [13:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    logic [31:0] expOut0;
  } vec_t;

  vec_t vecs[$];

  lsu_hs #(.DMEM_AW(10), .N_IN(8), .N_OUT(2)) dut (
    .clock_i        (clock),
    .reset_ni       (resetN),
    .req_valid_i    (reqValid),
    .req_ready_o    (reqReady),
    .req_we_i       (reqWe),
    .req_addr_i     (reqAddr),
    .req_size_i     (reqSize),
    .req_unsigned_i (reqUnsigned),
    .req_wdata_i    (reqWdata),
    .rsp_valid_o    (rspValid),
    .rsp_ready_i    (rspReady),
    .rsp_rdata_o    (rspRdata),
    .rsp_err_o      (rspErr),
    .io_in_i        (ioIn),
    .io_out_o       (ioOut)
  );

  always #5 clock = ~clock;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one request, wait (bounded) for acceptance, check the response one
  // cycle later, let it be consumed, then check output register 0.
  task automatic applyStimulus(input vec_t v);
    int n;
    @(negedge clock);
    reqWe       = v.we;
    reqAddr     = v.addr;
    reqSize     = v.size;
    reqUnsigned = v.uns;
    reqWdata    = v.wdata;
    reqValid    = 1'b1;
    rspReady    = 1'b1;
    n = 0;
    while (!reqReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!reqReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s accept: req_ready_o stayed 0, expected 1", v.name);
    end
    @(posedge clock);
    #1;
    reqValid = 1'b0;
    checkOutput({v.name, " rsp_valid"}, {31'b0, rspValid}, 32'd1);
    checkOutput({v.name, " rdata"}, rspRdata, v.expRdata);
    checkOutput({v.name, " err"}, {31'b0, rspErr}, {31'b0, v.expErr});
    @(posedge clock);
    #1;
    checkOutput({v.name, " io_out0"}, ioOut[31:0], v.expOut0);
  endtask

  initial begin
    resetN      = 1'b0;
    reqValid    = 1'b0;
    reqWe       = 1'b0;
    reqAddr     = '0;
    reqSize     = 2'b10;
    reqUnsigned = 1'b0;
    reqWdata    = '0;
    rspReady    = 1'b1;
    for (int k = 0; k < 8; k++) ioIn[k*32 +: 32] = 32'h1111_1111 * k;
    ioIn[3*32 +: 32] = 32'h8000_0001;

    //          name        we    addr      size   uns   wdata          rdata          err   out0
    vecs.push_back('{"st_w_10",   1'b1, 14'h0010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'h00000000});
    vecs.push_back('{"ld_bs_13",  1'b0, 14'h0013, 2'b00, 1'b0, 32'h0,        32'hFFFFFFDE, 1'b0, 32'h00000000});
    vecs.push_back('{"ld_bu_13",  1'b0, 14'h0013, 2'b00, 1'b1, 32'h0,        32'h000000DE, 1'b0, 32'h00000000});
    vecs.push_back('{"st_h_2002", 1'b1, 14'h2002, 2'b01, 1'b0, 32'h00001234, 32'h00000000, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_hs_2002",1'b0, 14'h2002, 2'b01, 1'b0, 32'h0,        32'h00001234, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_w_06",   1'b0, 14'h0006, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1, 32'h12340000});
    vecs.push_back('{"ld_w_10",   1'b0, 14'h0010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 32'h12340000});
    vecs.push_back('{"st_3000",   1'b1, 14'h3000, 2'b10, 1'b0, 32'h55555555, 32'h00000000, 1'b1, 32'h12340000});
    vecs.push_back('{"st_1000",   1'b1, 14'h1000, 2'b10, 1'b0, 32'h55555555, 32'h00000000, 1'b1, 32'h12340000});
    vecs.push_back('{"ld_w_100C", 1'b0, 14'h100C, 2'b10, 1'b0, 32'h0,        32'h80000001, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_bs_100F",1'b0, 14'h100F, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_w_1020", 1'b0, 14'h1020, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1, 32'h12340000});
    vecs.push_back('{"ld_w_2008", 1'b0, 14'h2008, 2'b10, 1'b0, 32'h0,        32'h00000000, 1'b1, 32'h12340000});
    vecs.push_back('{"ld_size11", 1'b0, 14'h0000, 2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1, 32'h12340000});
    vecs.push_back('{"st_b_11",   1'b1, 14'h0011, 2'b00, 1'b0, 32'h000000A5, 32'h00000000, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_w_10b",  1'b0, 14'h0010, 2'b10, 1'b0, 32'h0,        32'hDEADA5EF, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_hu_12",  1'b0, 14'h0012, 2'b01, 1'b1, 32'h0,        32'h0000DEAD, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_hs_12",  1'b0, 14'h0012, 2'b01, 1'b0, 32'h0,        32'hFFFFDEAD, 1'b0, 32'h12340000});
    vecs.push_back('{"st_h_2006", 1'b1, 14'h2006, 2'b01, 1'b0, 32'hFFFF5678, 32'h00000000, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_w_2004", 1'b0, 14'h2004, 2'b10, 1'b0, 32'h0,        32'h56780000, 1'b0, 32'h12340000});
    vecs.push_back('{"ld_h_11",   1'b0, 14'h0011, 2'b01, 1'b0, 32'h0,        32'h00000000, 1'b1, 32'h12340000});
    vecs.push_back('{"ld_bu_1005",1'b0, 14'h1005, 2'b00, 1'b1, 32'h0,        32'h00000011, 1'b0, 32'h12340000});
    vecs.push_back('{"st_b_2000", 1'b1, 14'h2000, 2'b00, 1'b0, 32'h00000077, 32'h00000000, 1'b0, 32'h12340077});
    vecs.push_back('{"ld_w_2000", 1'b0, 14'h2000, 2'b10, 1'b0, 32'h0,        32'h12340077, 1'b0, 32'h12340077});
    vecs.push_back('{"st_w_2001", 1'b1, 14'h2001, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h12340077});

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset rsp_valid", {31'b0, rspValid}, 32'd0);
    checkOutput("reset rdata", rspRdata, 32'd0);
    checkOutput("reset err", {31'b0, rspErr}, 32'd0);
    checkOutput("reset io_out", ioOut[31:0] | ioOut[63:32], 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    #1;
    checkOutput("reset req_ready", {31'b0, reqReady}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Backpressure: load held for five stalled cycles while a second request
    // waits; the second one is taken only after the response is consumed.
    @(negedge clock);
    reqWe = 1'b0; reqAddr = 14'h0010; reqSize = 2'b10; reqUnsigned = 1'b0;
    reqValid = 1'b1;
    rspReady = 1'b0;
    @(posedge clock);
    #1;
    reqAddr = 14'h2000;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d rsp_valid", i), {31'b0, rspValid}, 32'd1);
      checkOutput($sformatf("bp%0d rdata", i), rspRdata, 32'hDEADA5EF);
      checkOutput($sformatf("bp%0d req_ready", i), {31'b0, reqReady}, 32'd0);
      @(posedge clock);
      #1;
    end
    rspReady = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("bp release req_ready", {31'b0, reqReady}, 32'd1);
    checkOutput("bp release rsp_valid", {31'b0, rspValid}, 32'd0);
    @(posedge clock);
    #1;
    reqValid = 1'b0;
    checkOutput("bp second rsp_valid", {31'b0, rspValid}, 32'd1);
    checkOutput("bp second rdata", rspRdata, 32'h12340077);
    @(posedge clock);
    #1;

    // Reset while a response is pending; a request presented during reset
    // must not be taken.
    reqAddr = 14'h0010;
    reqValid = 1'b1;
    rspReady = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst pre rsp_valid", {31'b0, rspValid}, 32'd1);
    resetN = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst rsp_valid", {31'b0, rspValid}, 32'd0);
    checkOutput("rst io_out0", ioOut[31:0], 32'd0);
    checkOutput("rst io_out1", ioOut[63:32], 32'd0);
    checkOutput("rst rdata", rspRdata, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("rst held rsp_valid", {31'b0, rspValid}, 32'd0);
    reqValid = 1'b0;
    rspReady = 1'b1;
    resetN = 1'b1;
    #1;
    checkOutput("rst release req_ready", {31'b0, reqReady}, 32'd1);
    @(posedge clock);
    #1;
    checkOutput("rst idle rsp_valid", {31'b0, rspValid}, 32'd0);
    applyStimulus('{"post_rst_ld", 1'b0, 14'h2000, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0, 32'h00000000});
    applyStimulus('{"post_rst_dm", 1'b0, 14'h0010, 2'b10, 1'b0, 32'h0, 32'hDEADA5EF, 1'b0, 32'h00000000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
